fetch_ifid_stage: RTL and testbench
===================================

Name: fetch_ifid_stage

Overview:
- Fetch stage plus IF/ID pipeline register of the 5-stage MIPS core.
- Holds the PC and drives the instruction-memory address.
- Latches the fetched instruction and PC+4 into IF/ID for the decode stage.
- Consumes the OR of the decode-stage stall requests (load-use and branch-operand stall_beq), and the branch/jump redirect resolved in ID.
- Also keeps saturating stall and flush event counters for performance debug.

Parameters:
- PC_W, 32, PC and target width in bits.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, bubble instruction (sll $0,$0,0) inserted on flush.
- CNT_W, 16, width of each performance counter.

Ports:
- clk  in  1  Rising-edge clock; the only clock.
- rst  in  1  Synchronous, active-high reset.
- stall  in  1  Hold PC and IF/ID this cycle (OR of hazard-unit stalls).
- branch_taken  in  1  Branch resolved taken in ID.
- branch_target  in  PC_W  Branch destination.
- jump  in  1  j/jal decoded in ID.
- jump_target  in  PC_W  Jump destination.
- imem_addr  out  PC_W  Instruction-memory address; equals the PC register.
- imem_rdata  in  32  Instruction word; combinational, same-cycle read.
- if2id_instr  out  32  Latched instruction.
- if2id_pc4  out  PC_W  Latched PC+4 of that instruction.
- if2id_valid  out  1  IF/ID holds a real instruction (0 = bubble).
- misalign_err  out  1  Sticky flag: a redirect target had bits[1:0] != 0.
- stall_cycles  out  CNT_W  Count of cycles with stall applied.
- flush_count  out  CNT_W  Count of redirects taken.

Behaviour:
- Reset values:
  - pc = RESET_PC
  - if2id_instr = NOP_INSTR, if2id_pc4 = 0, if2id_valid = 0
  - misalign_err = 0, stall_cycles = 0, flush_count = 0
- Reset is sampled at the clock edge only. When rst = 1, every other input is ignored that cycle, including mid-stall or mid-redirect.
- imem_addr = pc (combinational from the register). Fetch latency: an instruction appears in IF/ID one edge after its PC is presented.
- Per-edge priority, highest first: rst > stall > redirect > sequential.
  - stall = 1:
    - pc and all IF/ID fields hold.
    - branch_taken and jump are ignored. Operands are not ready; the same branch re-resolves after the stall drops.
    - stall_cycles increments.
  - redirect (stall = 0 and (branch_taken or jump)):
    - pc <= target with bits[1:0] forced to 0.
    - IF/ID <= bubble: if2id_instr = NOP_INSTR, if2id_pc4 = 0, if2id_valid = 0. This squashes the wrong-path instruction fetched this cycle.
    - flush_count increments.
    - If target bits[1:0] != 0, misalign_err <= 1.
  - sequential (stall = 0, no redirect):
    - pc <= pc + 4, modulo 2^PC_W; all-ones wraps to 0 with no error.
    - if2id_instr <= imem_rdata, if2id_pc4 <= pc + 4, if2id_valid <= 1.
- branch_taken and jump both high: branch_target wins. This is illegal from a single ID instruction; a bench assertion flags it.
- Counters saturate at 2^CNT_W - 1 and clear only on reset.
- misalign_err is sticky until reset.
- The first instruction (at RESET_PC) is valid in IF/ID after the first non-reset edge. if2id_valid = 0 during and immediately after reset.
- No combinational path from stall, branch_taken or jump to imem_addr. Redirects take effect on the next cycle's fetch.

Decomposition:
- Shared package mips_pipe_pkg holds:
  - instruction width (32) and PC increment (4)
  - NOP_INSTR
  - the IF/ID bundle struct {instr, pc4, valid}, reused by the decode stage and the hazard units
- One natural sub-module: sat_counter (parameter W; inputs clk, rst, inc; output count). Instantiated twice, for stall_cycles and flush_count.

Test Plan:
- Reset then free-run 4 cycles with imem returning {A,B,C,D}:
  - imem_addr goes 0, 4, 8, 12.
  - IF/ID shows A/pc4=4, then B/8, then C/12, valid = 1 from the 2nd edge.
- stall = 1 for 3 cycles at pc = 8:
  - pc stays 8 and IF/ID holds B/8.
  - stall_cycles = 3.
  - Fetch resumes at 8 when stall drops.
- branch_taken = 1, branch_target = 0x40 with stall = 0:
  - Next edge pc = 0x40 and IF/ID is a bubble (NOP, valid = 0); flush_count = 1.
  - The following edge latches the instruction at 0x40 with pc4 = 0x44.
- stall = 1 together with branch_taken = 1 for 2 cycles, then branch_taken alone:
  - No redirect during the stall; redirect to the target after.
  - flush_count increments once, stall_cycles by 2.
- jump = 1, jump_target = 0x103:
  - pc = 0x100 and misalign_err = 1.
  - misalign_err stays 1 after 10 more cycles.
  - Cleared by rst.
- Assert rst mid-stall with pc = 0x20:
  - After the edge, pc = RESET_PC, if2id_valid = 0, counters = 0.
- Bonus check, force counter to 0xFFFE then stall 3 cycles:
  - stall_cycles saturates at 0xFFFF.

Source files
------------

// File: rtl/mips_pipe_pkg.sv
// Shared definitions for the 5-stage MIPS pipeline: widths, PC step,
// the bubble instruction and the IF/ID bundle used by fetch, decode and
// the hazard units.
package mips_pipe_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned PC_INC  = 4;

    // sll $0,$0,0 encodes as all zeros
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc4;
        logic               valid;
    } ifid_t;

endpackage

// File: rtl/fetch_ifid_stage_if.sv
// Fetch-stage bus: hazard/redirect inputs from ID, instruction-memory
// port, the IF/ID register outputs and the debug status/counters.
interface fetch_ifid_stage_if #(
    parameter int unsigned PC_W  = 32,
    parameter int unsigned CNT_W = 16
);
    import mips_pipe_pkg::*;

    logic                stall;
    logic                branch_taken;
    logic [PC_W-1:0]     branch_target;
    logic                jump;
    logic [PC_W-1:0]     jump_target;
    logic [PC_W-1:0]     imem_addr;
    logic [INSTR_W-1:0]  imem_rdata;
    logic [INSTR_W-1:0]  if2id_instr;
    logic [PC_W-1:0]     if2id_pc4;
    logic                if2id_valid;
    logic                misalign_err;
    logic [CNT_W-1:0]    stall_cycles;
    logic [CNT_W-1:0]    flush_count;

    // Fetch stage side
    modport master (
        input  stall, branch_taken, branch_target, jump, jump_target, imem_rdata,
        output imem_addr, if2id_instr, if2id_pc4, if2id_valid,
        output misalign_err, stall_cycles, flush_count
    );

    // Surrounding pipeline / memory side
    modport slave (
        output stall, branch_taken, branch_target, jump, jump_target, imem_rdata,
        input  imem_addr, if2id_instr, if2id_pc4, if2id_valid,
        input  misalign_err, stall_cycles, flush_count
    );

endinterface

// File: rtl/fetch_ifid_stage_sat_counter.sv
// Saturating event counter: counts cycles with inc high, sticks at all-ones,
// clears only on reset.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: step by one unless already saturated
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end
    end

    // Count register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/fetch_ifid_stage.sv
// Fetch stage and IF/ID pipeline register. Holds the PC, presents it to the
// instruction memory, latches the fetched word plus PC+4 for decode, and
// applies stalls and ID-resolved redirects (stall beats redirect).
module fetch_ifid_stage
    import mips_pipe_pkg::*;
#(
    parameter int unsigned        PC_W      = 32,
    parameter logic [PC_W-1:0]    RESET_PC  = '0,
    parameter logic [INSTR_W-1:0] NOP_INSTR = mips_pipe_pkg::NOP_INSTR,
    parameter int unsigned        CNT_W     = 16
) (
    input logic              clk,
    input logic              rst,
    fetch_ifid_stage_if.master bus
);

    logic [PC_W-1:0]  pc_q;
    logic [PC_W-1:0]  pc_d;
    ifid_t            ifid_q;
    ifid_t            ifid_d;
    logic             misalign_q;
    logic             misalign_d;

    logic             redirect;
    logic             flush_inc;
    logic [PC_W-1:0]  target;
    logic [PC_W-1:0]  pc_plus4;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    // Branch wins over jump if both are ever asserted together
    assign redirect  = bus.branch_taken | bus.jump;
    assign target    = bus.branch_taken ? bus.branch_target : bus.jump_target;
    assign pc_plus4  = pc_q + PC_W'(PC_INC);
    assign flush_inc = ~bus.stall & redirect;

    // Next-state selection: stall holds everything, redirect squashes the
    // wrong-path fetch into a bubble, otherwise advance sequentially
    always_comb begin
        pc_d       = pc_q;
        ifid_d     = ifid_q;
        misalign_d = misalign_q;
        if (!bus.stall) begin
            if (redirect) begin
                pc_d         = {target[PC_W-1:2], 2'b00};
                ifid_d.instr = NOP_INSTR;
                ifid_d.pc4   = '0;
                ifid_d.valid = 1'b0;
                if (target[1:0] != 2'b00) begin
                    misalign_d = 1'b1;
                end
            end else begin
                pc_d         = pc_plus4;
                ifid_d.instr = bus.imem_rdata;
                ifid_d.pc4   = ADDR_W'(pc_plus4);
                ifid_d.valid = 1'b1;
            end
        end
    end

    // PC, IF/ID and sticky error registers; reset overrides all inputs
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q         <= RESET_PC;
            ifid_q.instr <= NOP_INSTR;
            ifid_q.pc4   <= '0;
            ifid_q.valid <= 1'b0;
            misalign_q   <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            ifid_q     <= ifid_d;
            misalign_q <= misalign_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (bus.stall),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (flush_inc),
        .count (flush_cnt)
    );

    assign bus.imem_addr    = pc_q;
    assign bus.if2id_instr  = ifid_q.instr;
    assign bus.if2id_pc4    = PC_W'(ifid_q.pc4);
    assign bus.if2id_valid  = ifid_q.valid;
    assign bus.misalign_err = misalign_q;
    assign bus.stall_cycles = stall_cnt;
    assign bus.flush_count  = flush_cnt;

endmodule

// File: tb/tb_fetch_ifid_stage.sv
// Bench for fetch_ifid_stage: directed stimulus, a cycle-level reference
// model of the fetch rules compared on every falling edge, plus literal
// expectations at key points.
module tb_fetch_ifid_stage;

    logic clk;
    logic rst;
    logic chk_en;

    int n_cmp;
    int n_fail;

    fetch_ifid_stage_if #(.PC_W(32), .CNT_W(16)) bus_if ();

    fetch_ifid_stage #(
        .PC_W      (32),
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (32'h0000_0000),
        .CNT_W     (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory contents: word at address a is {C0DE, a[15:0]}
    function automatic logic [31:0] instr_at(input logic [31:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    assign bus_if.imem_rdata = instr_at(bus_if.imem_addr);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model of the architectural state
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_pc4;
    logic        m_valid;
    logic        m_mis;
    logic [15:0] m_stalls;
    logic [15:0] m_flush;

    always @(posedge clk) begin
        logic [31:0] tgt;
        tgt = bus_if.branch_taken ? bus_if.branch_target : bus_if.jump_target;
        if (rst) begin
            m_pc     <= 32'h0;
            m_instr  <= 32'h0;
            m_pc4    <= 32'h0;
            m_valid  <= 1'b0;
            m_mis    <= 1'b0;
            m_stalls <= 16'h0;
            m_flush  <= 16'h0;
        end else if (bus_if.stall) begin
            if (m_stalls != 16'hFFFF) m_stalls <= m_stalls + 16'd1;
        end else if (bus_if.branch_taken || bus_if.jump) begin
            m_pc    <= tgt - (tgt % 4);
            m_instr <= 32'h0;
            m_pc4   <= 32'h0;
            m_valid <= 1'b0;
            if (tgt % 4 != 0) m_mis <= 1'b1;
            if (m_flush != 16'hFFFF) m_flush <= m_flush + 16'd1;
        end else begin
            m_instr <= instr_at(m_pc);
            m_pc4   <= m_pc + 32'd4;
            m_valid <= 1'b1;
            m_pc    <= m_pc + 32'd4;
        end
    end

    // Both redirects at once cannot come from a single ID instruction
    always @(posedge clk) begin
        if (!rst) begin
            assert (!(bus_if.branch_taken && bus_if.jump))
                else $warning("branch_taken and jump asserted together");
        end
    end

    // Compare all outputs against the model away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            chk("imem_addr",    bus_if.imem_addr,    m_pc);
            chk("if2id_instr",  bus_if.if2id_instr,  m_instr);
            chk("if2id_pc4",    bus_if.if2id_pc4,    m_pc4);
            chk("if2id_valid",  bus_if.if2id_valid,  m_valid);
            chk("misalign_err", bus_if.misalign_err, m_mis);
            chk("stall_cycles", bus_if.stall_cycles, m_stalls);
            chk("flush_count",  bus_if.flush_count,  m_flush);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        chk_en = 1'b0;
        rst    = 1'b1;
        bus_if.stall         = 1'b0;
        bus_if.branch_taken  = 1'b0;
        bus_if.branch_target = 32'h0;
        bus_if.jump          = 1'b0;
        bus_if.jump_target   = 32'h0;

        // Reset state
        tick();
        chk_en = 1'b1;
        tick();
        chk("rst_pc",    bus_if.imem_addr,   32'h0);
        chk("rst_valid", bus_if.if2id_valid, 1'b0);
        chk("rst_instr", bus_if.if2id_instr, 32'h0);
        chk("rst_cnt",   bus_if.stall_cycles, 16'h0);

        // Free run
        rst = 1'b0;
        tick();
        chk("run1_addr",  bus_if.imem_addr,   32'h4);
        chk("run1_instr", bus_if.if2id_instr, 32'hC0DE_0000);
        chk("run1_pc4",   bus_if.if2id_pc4,   32'h4);
        chk("run1_valid", bus_if.if2id_valid, 1'b1);
        tick();
        chk("run2_addr",  bus_if.imem_addr,   32'h8);
        chk("run2_instr", bus_if.if2id_instr, 32'hC0DE_0004);
        chk("run2_pc4",   bus_if.if2id_pc4,   32'h8);

        // Stall 3 cycles at pc = 8
        bus_if.stall = 1'b1;
        repeat (3) tick();
        chk("stall_addr",  bus_if.imem_addr,    32'h8);
        chk("stall_instr", bus_if.if2id_instr,  32'hC0DE_0004);
        chk("stall_cnt",   bus_if.stall_cycles, 16'd3);
        bus_if.stall = 1'b0;
        tick();
        chk("resume_addr",  bus_if.imem_addr,   32'hC);
        chk("resume_instr", bus_if.if2id_instr, 32'hC0DE_0008);
        chk("resume_pc4",   bus_if.if2id_pc4,   32'hC);
        tick();

        // Branch to 0x40
        bus_if.branch_taken  = 1'b1;
        bus_if.branch_target = 32'h40;
        tick();
        chk("br_addr",  bus_if.imem_addr,   32'h40);
        chk("br_valid", bus_if.if2id_valid, 1'b0);
        chk("br_instr", bus_if.if2id_instr, 32'h0);
        chk("br_flush", bus_if.flush_count, 16'd1);
        bus_if.branch_taken = 1'b0;
        tick();
        chk("br_next_instr", bus_if.if2id_instr, 32'hC0DE_0040);
        chk("br_next_pc4",   bus_if.if2id_pc4,   32'h44);

        // Stall with branch pending, then branch alone
        bus_if.stall         = 1'b1;
        bus_if.branch_taken  = 1'b1;
        bus_if.branch_target = 32'h80;
        repeat (2) tick();
        chk("stbr_addr",  bus_if.imem_addr,    32'h44);
        chk("stbr_flush", bus_if.flush_count,  16'd1);
        chk("stbr_stall", bus_if.stall_cycles, 16'd5);
        bus_if.stall = 1'b0;
        tick();
        chk("stbr_redir_addr",  bus_if.imem_addr,   32'h80);
        chk("stbr_redir_flush", bus_if.flush_count, 16'd2);
        bus_if.branch_taken = 1'b0;
        tick();

        // Misaligned jump
        bus_if.jump        = 1'b1;
        bus_if.jump_target = 32'h103;
        tick();
        chk("jmp_addr", bus_if.imem_addr,    32'h100);
        chk("jmp_mis",  bus_if.misalign_err, 1'b1);
        bus_if.jump = 1'b0;
        repeat (10) tick();
        chk("jmp_mis_sticky", bus_if.misalign_err, 1'b1);

        // Both redirects: branch target wins
        bus_if.branch_taken  = 1'b1;
        bus_if.branch_target = 32'h200;
        bus_if.jump          = 1'b1;
        bus_if.jump_target   = 32'h300;
        tick();
        chk("both_addr", bus_if.imem_addr, 32'h200);
        bus_if.branch_taken = 1'b0;
        bus_if.jump         = 1'b0;
        tick();

        // Reset mid-stall at pc = 0x20 with a branch pending
        bus_if.jump        = 1'b1;
        bus_if.jump_target = 32'h20;
        tick();
        bus_if.jump  = 1'b0;
        bus_if.stall = 1'b1;
        tick();
        chk("pre_rst_addr", bus_if.imem_addr, 32'h20);
        rst                 = 1'b1;
        bus_if.branch_taken = 1'b1;
        tick();
        chk("mid_rst_addr",  bus_if.imem_addr,    32'h0);
        chk("mid_rst_valid", bus_if.if2id_valid,  1'b0);
        chk("mid_rst_stall", bus_if.stall_cycles, 16'h0);
        chk("mid_rst_flush", bus_if.flush_count,  16'h0);
        chk("mid_rst_mis",   bus_if.misalign_err, 1'b0);
        rst                 = 1'b0;
        bus_if.stall        = 1'b0;
        bus_if.branch_taken = 1'b0;
        tick();
        chk("post_rst_addr",  bus_if.imem_addr,   32'h4);
        chk("post_rst_valid", bus_if.if2id_valid, 1'b1);

        // PC wrap at the top of the address space
        bus_if.jump        = 1'b1;
        bus_if.jump_target = 32'hFFFF_FFFC;
        tick();
        bus_if.jump = 1'b0;
        tick();
        chk("wrap_addr",  bus_if.imem_addr,    32'h0);
        chk("wrap_pc4",   bus_if.if2id_pc4,    32'h0);
        chk("wrap_instr", bus_if.if2id_instr,  32'hC0DE_FFFC);
        chk("wrap_mis",   bus_if.misalign_err, 1'b0);

        // Stall counter saturation
        rst = 1'b1;
        tick();
        rst          = 1'b0;
        bus_if.stall = 1'b1;
        repeat (65534) tick();
        chk("sat_fffe", bus_if.stall_cycles, 16'hFFFE);
        repeat (3) tick();
        chk("sat_ffff", bus_if.stall_cycles, 16'hFFFF);
        bus_if.stall = 1'b0;
        tick();
        chk("sat_hold", bus_if.stall_cycles, 16'hFFFF);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
